// File: rtl/lfsr_pkg.sv
// Shared types and widths for the LFSR pattern generator and its deserializer.
package lfsr_pkg;

    localparam int LFSR_WORD_W = 4;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/lfsr_deserializer.sv
// Reassembles the LFSR generator's serial stream (bit 0 first) into parallel
// words on a valid/ready port, flagging truncated frames and dropped words.
module lfsr_deserializer
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_WORD_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SER_IN,
    input  logic             SER_VLD,
    input  logic             PAR_RDY,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             PAR_VLD,
    output logic             FRAME_ERR,
    output logic             OVERRUN,
    output logic [CNT_W-1:0] WORD_CNT
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    logic [WIDTH-1:0] word;
    logic             xfer;
    logic             slot_free;

    always_comb begin
        word            = sreg_q;
        word[cnt_q]     = SER_IN;
        xfer            = vld_q & PAR_RDY;
        slot_free       = ~vld_q | PAR_RDY;

        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        vld_d   = vld_q & ~PAR_RDY;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;
        wcnt_d  = wcnt_q;

        if (xfer && wcnt_q != '1) begin
            wcnt_d = wcnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (SER_VLD) begin
                    sreg_d    = '0;
                    sreg_d[0] = SER_IN;
                    cnt_d     = BW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!SER_VLD) begin
                    // truncated frame: drop the partial word
                    ferr_d  = 1'b1;
                    sreg_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    if (slot_free) begin
                        par_d = word;
                        vld_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                    sreg_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    sreg_d = word;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign PAR_OUT   = par_q;
    assign PAR_VLD   = vld_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;
    assign WORD_CNT  = wcnt_q;

endmodule

// File: tb/tb_lfsr_deserializer.sv
// Directed plus random stimulus for lfsr_deserializer, checked every cycle
// against a bit-list reference model; a second instance has CNT_W=2.
module tb_lfsr_deserializer;
    import lfsr_pkg::*;

    localparam int W = LFSR_WORD_W;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         SER_IN = 1'b0;
    logic         SER_VLD = 1'b0;
    logic         PAR_RDY = 1'b0;
    logic [W-1:0] PAR_OUT, PAR_OUT2;
    logic         PAR_VLD, PAR_VLD2;
    logic         FRAME_ERR, FRAME_ERR2;
    logic         OVERRUN, OVERRUN2;
    logic [7:0]   WORD_CNT;
    logic [1:0]   WORD_CNT2;

    int total = 0;
    int bad   = 0;

    int           m_n;
    int           m_acc;
    logic [W-1:0] m_par;
    bit           m_vld, m_ferr, m_ovr;
    int           m_cnt;

    always #5 CLK = ~CLK;

    lfsr_deserializer #(.WIDTH(W), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .SER_IN(SER_IN), .SER_VLD(SER_VLD),
        .PAR_RDY(PAR_RDY), .PAR_OUT(PAR_OUT), .PAR_VLD(PAR_VLD),
        .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .WORD_CNT(WORD_CNT)
    );

    lfsr_deserializer #(.WIDTH(W), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .SER_IN(SER_IN), .SER_VLD(SER_VLD),
        .PAR_RDY(PAR_RDY), .PAR_OUT(PAR_OUT2), .PAR_VLD(PAR_VLD2),
        .FRAME_ERR(FRAME_ERR2), .OVERRUN(OVERRUN2), .WORD_CNT(WORD_CNT2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_acc = 0; m_par = '0;
        m_vld = 0; m_ferr = 0; m_ovr = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        int sat8, sat2;
        sat8 = (m_cnt > 255) ? 255 : m_cnt;
        sat2 = (m_cnt > 3) ? 3 : m_cnt;
        chk({tag, ".par_out"}, 32'(PAR_OUT), 32'(m_par));
        chk({tag, ".par_vld"}, 32'(PAR_VLD), 32'(m_vld));
        chk({tag, ".frame_err"}, 32'(FRAME_ERR), 32'(m_ferr));
        chk({tag, ".overrun"}, 32'(OVERRUN), 32'(m_ovr));
        chk({tag, ".word_cnt"}, 32'(WORD_CNT), 32'(sat8));
        chk({tag, ".word_cnt2"}, 32'(WORD_CNT2), 32'(sat2));
    endtask

    // Reference: collect bits arithmetically; a full word either lands in
    // the output slot or is lost, and a gap after a partial word is an error.
    task automatic step(input string tag, input bit sv, input bit si,
                        input bit rdy);
        bit xfer;
        SER_VLD = sv;
        SER_IN  = si;
        PAR_RDY = rdy;
        xfer   = m_vld && rdy;
        if (xfer) m_cnt++;
        m_ferr = 0;
        if (sv) begin
            m_acc = m_acc + (int'(si) << m_n);
            m_n++;
            if (m_n == W) begin
                if (!m_vld || rdy) begin
                    m_par = W'(m_acc);
                    m_vld = 1;
                end else begin
                    m_ovr = 1;
                    if (xfer) m_vld = 0;
                end
                m_n = 0;
                m_acc = 0;
            end else if (xfer) begin
                m_vld = 0;
            end
        end else begin
            if (m_n > 0) m_ferr = 1;
            m_n = 0;
            m_acc = 0;
            if (xfer) m_vld = 0;
        end
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic word(input string tag, input logic [W-1:0] w,
                        input bit rdy);
        for (int i = 0; i < W; i++) step(tag, 1'b1, w[i], rdy);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(posedge CLK);
        #1;
        RST = 1'b1;

        word("basic", 4'b1101, 1'b1);
        chk("basic.value", 32'(PAR_OUT), 32'h d);
        step("basic.drain", 0, 0, 1);
        chk("basic.one_cycle", 32'(PAR_VLD), 32'h0);

        word("b2b0", 4'b0110, 1'b1);
        chk("b2b.first", 32'(PAR_OUT), 32'h6);
        word("b2b1", 4'b1111, 1'b1);
        chk("b2b.second", 32'(PAR_OUT), 32'hf);
        step("b2b.drain", 0, 0, 1);

        step("trunc", 1, 1, 1);
        step("trunc", 1, 0, 1);
        step("trunc.gap", 0, 1, 1);
        chk("trunc.pulse", 32'(FRAME_ERR), 32'h1);
        step("trunc.after", 0, 0, 1);
        chk("trunc.one_cycle", 32'(FRAME_ERR), 32'h0);
        word("trunc.clean", 4'b0011, 1'b1);
        chk("trunc.clean_val", 32'(PAR_OUT), 32'h3);
        step("trunc.drain", 0, 0, 1);

        word("simul.a", 4'b0001, 1'b0);
        for (int i = 0; i < W; i++)
            step("simul.b", 1'b1, (i == W - 1), (i == W - 1));
        chk("simul.value", 32'(PAR_OUT), 32'h8);
        chk("simul.vld", 32'(PAR_VLD), 32'h1);
        chk("simul.ovr", 32'(OVERRUN), 32'h0);
        step("simul.drain", 0, 0, 1);

        word("bp.a", 4'b1010, 1'b0);
        word("bp.b", 4'b0101, 1'b0);
        chk("bp.hold", 32'(PAR_OUT), 32'ha);
        chk("bp.ovr", 32'(OVERRUN), 32'h1);
        step("bp.accept", 0, 0, 1);
        chk("bp.ovr_sticky", 32'(OVERRUN), 32'h1);

        for (int i = 0; i < 3; i++) step("rst.part", 1, 1, 1);
        RST = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        #2;
        RST = 1'b1;
        word("rst.after", 4'b1001, 1'b1);
        chk("rst.after_val", 32'(PAR_OUT), 32'h9);

        for (int i = 0; i < 5; i++) word("sat", W'(i + 2), 1'b1);
        step("sat.drain", 0, 0, 1);
        chk("sat.cnt2", 32'(WORD_CNT2), 32'h3);
        chk("sat.cnt8", 32'(WORD_CNT), 32'h6);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 7) != 0), 1'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
